// File: rtl/fixed_point_addsub_pipe.sv
// Two-stage elastic fixed-point adder/subtractor: align and add at full precision,
// then round and saturate (or wrap) into the output Q format.
module fixed_point_addsub_pipe #(
    parameter int A_FRAC_LEN = 8,
    parameter int A_WORD_LEN = 9,
    parameter int B_FRAC_LEN = 8,
    parameter int B_WORD_LEN = 9,
    parameter int C_FRAC_LEN = 8,
    parameter int C_WORD_LEN = 9,
    parameter int ROUND_MODE = 0,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [A_WORD_LEN-1:0] a,
    input  logic [B_WORD_LEN-1:0] b,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [C_WORD_LEN-1:0] c,
    output logic                  ovf
);

    localparam int A_INT  = A_WORD_LEN - A_FRAC_LEN;
    localparam int B_INT  = B_WORD_LEN - B_FRAC_LEN;
    localparam int F_AB   = (A_FRAC_LEN > B_FRAC_LEN) ? A_FRAC_LEN : B_FRAC_LEN;
    localparam int F      = (F_AB > C_FRAC_LEN) ? F_AB : C_FRAC_LEN;
    localparam int I      = (A_INT > B_INT) ? A_INT : B_INT;
    localparam int EW     = I + F;
    localparam int SW     = EW + 1;
    localparam int D      = F - C_FRAC_LEN;
    localparam int RW     = SW + 1;
    localparam int CW     = (RW > C_WORD_LEN + 1) ? RW : C_WORD_LEN + 1;
    localparam int RND_SH = (D > 0) ? D - 1 : 0;

    localparam logic signed [RW-1:0] RND_INC =
        (ROUND_MODE == 1 && D > 0) ? (RW'(1) << RND_SH) : '0;
    localparam logic signed [CW-1:0] C_MAX =
        {{(CW - C_WORD_LEN + 1){1'b0}}, {(C_WORD_LEN - 1){1'b1}}};
    localparam logic signed [CW-1:0] C_MIN =
        {{(CW - C_WORD_LEN + 1){1'b1}}, {(C_WORD_LEN - 1){1'b0}}};

    logic                  s1_valid;
    logic signed [SW-1:0]  s1_sum;
    logic                  advance;

    logic signed [EW-1:0]  a_al;
    logic signed [EW-1:0]  b_al;
    logic signed [SW-1:0]  sum_d;

    logic signed [RW-1:0]  rnd;
    logic signed [RW-1:0]  q;
    logic signed [CW-1:0]  q_ext;
    logic                  pos_ovf;
    logic                  neg_ovf;
    logic [C_WORD_LEN-1:0] c_d;
    logic                  ovf_d;

    assign advance  = !out_valid || out_ready;
    assign in_ready = !s1_valid || advance;

    always_comb begin
        a_al  = EW'($signed(a)) <<< (F - A_FRAC_LEN);
        b_al  = EW'($signed(b)) <<< (F - B_FRAC_LEN);
        sum_d = sub ? (SW'(a_al) - SW'(b_al)) : (SW'(a_al) + SW'(b_al));
    end

    // One guard bit above the sum keeps the rounding increment from wrapping.
    always_comb begin
        rnd     = RW'(s1_sum) + RND_INC;
        q       = rnd >>> D;
        q_ext   = CW'(q);
        pos_ovf = q_ext > C_MAX;
        neg_ovf = q_ext < C_MIN;
        ovf_d   = pos_ovf || neg_ovf;
        c_d     = q_ext[C_WORD_LEN-1:0];
        if (SATURATE == 1 && pos_ovf) begin
            c_d = C_MAX[C_WORD_LEN-1:0];
        end else if (SATURATE == 1 && neg_ovf) begin
            c_d = C_MIN[C_WORD_LEN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sum    <= '0;
            out_valid <= 1'b0;
            c         <= '0;
            ovf       <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sum <= sum_d;
                end
            end
            if (advance) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    c   <= c_d;
                    ovf <= ovf_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_fixed_point_addsub_pipe.sv
// Directed bench: four parameterisations share one stimulus stream; results are hand-computed.
module tb_fixed_point_addsub_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       sub = 1'b0;
    logic       out_ready = 1'b1;
    logic [8:0] a = '0;
    logic [8:0] b = '0;

    logic       in_ready_s, out_valid_s, ovf_s;
    logic [8:0] c_s;
    logic       in_ready_w, out_valid_w, ovf_w;
    logic [8:0] c_w;
    logic       in_ready_0, out_valid_0, ovf_0;
    logic [4:0] c_0;
    logic       in_ready_1, out_valid_1, ovf_1;
    logic [4:0] c_1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fixed_point_addsub_pipe dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid_s), .out_ready(out_ready),
        .c(c_s), .ovf(ovf_s)
    );

    fixed_point_addsub_pipe #(.SATURATE(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid_w), .out_ready(out_ready),
        .c(c_w), .ovf(ovf_w)
    );

    fixed_point_addsub_pipe #(.C_FRAC_LEN(4), .C_WORD_LEN(5), .ROUND_MODE(0)) dut_r0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_0),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid_0), .out_ready(out_ready),
        .c(c_0), .ovf(ovf_0)
    );

    fixed_point_addsub_pipe #(.C_FRAC_LEN(4), .C_WORD_LEN(5), .ROUND_MODE(1)) dut_r1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_1),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid_1), .out_ready(out_ready),
        .c(c_1), .ovf(ovf_1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One isolated transaction with out_ready high; checks latency and all four results.
    task automatic applyStimulus(input string tag, input logic [8:0] av, input logic [8:0] bv,
                                 input logic sv,
                                 input logic [8:0] es, input logic eos,
                                 input logic [8:0] ew, input logic eow,
                                 input logic [4:0] e0, input logic eo0,
                                 input logic [4:0] e1, input logic eo1);
        int  cyc;
        bit  got;
        @(posedge clk); #1;
        a = av; b = bv; sub = sv; in_valid = 1'b1; out_ready = 1'b1;
        checkOutput({tag, "_in_ready"}, 32'(in_ready_s), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        got = 1'b0;
        while (cyc < 10 && !got) begin
            if (out_valid_s) begin
                got = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        checkOutput({tag, "_latency"}, got ? 32'(cyc) : 32'd0, 32'd2);
        checkOutput({tag, "_c_sat"},   32'(c_s),   32'(es));
        checkOutput({tag, "_ovf_sat"}, 32'(ovf_s), 32'(eos));
        checkOutput({tag, "_vld_wrap"}, 32'(out_valid_w), 32'd1);
        checkOutput({tag, "_c_wrap"},   32'(c_w),   32'(ew));
        checkOutput({tag, "_ovf_wrap"}, 32'(ovf_w), 32'(eow));
        checkOutput({tag, "_c_r0"},     32'(c_0),   32'(e0));
        checkOutput({tag, "_ovf_r0"},   32'(ovf_0), 32'(eo0));
        checkOutput({tag, "_c_r1"},     32'(c_1),   32'(e1));
        checkOutput({tag, "_ovf_r1"},   32'(ovf_1), 32'(eo1));
    endtask

    logic [8:0] sa  [0:5];
    logic [8:0] sb  [0:5];
    logic       ss  [0:5];
    logic [8:0] ec  [0:5];
    logic       eo  [0:5];

    initial begin
        int   n_in, n_out, stall;
        bit   seen, held, saw_nr;
        logic [8:0] held_c;
        logic held_ovf;

        sa = '{9'h010, 9'h0F0, 9'h1F0, 9'h100, 9'h080, 9'h155};
        sb = '{9'h020, 9'h020, 9'h008, 9'h0FF, 9'h080, 9'h0AA};
        ss = '{1'b0,   1'b0,   1'b1,   1'b0,   1'b1,   1'b1};
        ec = '{9'h030, 9'h0FF, 9'h1E8, 9'h1FF, 9'h000, 9'h100};
        eo = '{1'b0,   1'b1,   1'b0,   1'b0,   1'b0,   1'b1};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid_s), 32'd0);
        checkOutput("rst_c",         32'(c_s),         32'd0);
        checkOutput("rst_ovf",       32'(ovf_s),       32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rst_in_ready",  32'(in_ready_s),  32'd1);
        checkOutput("post_rst_out_valid", 32'(out_valid_s), 32'd0);

        // Directed vectors: sat Q1.8, wrap Q1.8, Q1.4 truncate, Q1.4 round
        applyStimulus("add_basic", 9'h040, 9'h020, 1'b0, 9'h060, 1'b0, 9'h060, 1'b0, 5'h06, 1'b0, 5'h06, 1'b0);
        applyStimulus("add_ovf",   9'h0C0, 9'h0C0, 1'b0, 9'h0FF, 1'b1, 9'h180, 1'b1, 5'h0F, 1'b1, 5'h0F, 1'b1);
        applyStimulus("sub_neg",   9'h100, 9'h001, 1'b1, 9'h100, 1'b1, 9'h0FF, 1'b1, 5'h10, 1'b1, 5'h10, 1'b0);
        applyStimulus("sub_minb",  9'h000, 9'h100, 1'b1, 9'h0FF, 1'b1, 9'h100, 1'b1, 5'h0F, 1'b1, 5'h0F, 1'b1);
        applyStimulus("rnd_pos",   9'h018, 9'h000, 1'b0, 9'h018, 1'b0, 9'h018, 1'b0, 5'h01, 1'b0, 5'h02, 1'b0);
        applyStimulus("rnd_neg",   9'h1E8, 9'h000, 1'b0, 9'h1E8, 1'b0, 9'h1E8, 1'b0, 5'h1E, 1'b0, 5'h1F, 1'b0);
        applyStimulus("rnd_ovf",   9'h0FF, 9'h001, 1'b1, 9'h0FE, 1'b0, 9'h0FE, 1'b0, 5'h0F, 1'b0, 5'h0F, 1'b1);

        // Back-to-back stream with a 3-cycle stall after the first result
        n_in = 0; n_out = 0; stall = 0;
        seen = 1'b0; held = 1'b0; saw_nr = 1'b0;
        held_c = '0; held_ovf = 1'b0;
        for (int cyc = 0; cyc < 60 && n_out < 6; cyc++) begin
            @(posedge clk); #1;
            if (out_valid_s && !seen) begin
                seen  = 1'b1;
                stall = 3;
            end
            if (stall > 0) begin
                out_ready = 1'b0;
                stall--;
            end else begin
                out_ready = 1'b1;
            end
            if (n_in < 6) begin
                in_valid = 1'b1;
                a = sa[n_in]; b = sb[n_in]; sub = ss[n_in];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (!in_ready_s) saw_nr = 1'b1;
            if (held) begin
                checkOutput("hold_valid", 32'(out_valid_s), 32'd1);
                checkOutput("hold_c",     32'(c_s),         32'(held_c));
                checkOutput("hold_ovf",   32'(ovf_s),       32'(held_ovf));
            end
            if (out_valid_s && !out_ready) begin
                held = 1'b1; held_c = c_s; held_ovf = ovf_s;
            end else begin
                held = 1'b0;
            end
            if (out_valid_s && out_ready) begin
                if (n_out < 6) begin
                    checkOutput("stream_c",   32'(c_s),   32'(ec[n_out]));
                    checkOutput("stream_ovf", 32'(ovf_s), 32'(eo[n_out]));
                end
                n_out++;
            end
            if (in_valid && in_ready_s) n_in++;
        end
        checkOutput("stream_out_count", n_out, 32'd6);
        checkOutput("stream_in_count",  n_in,  32'd6);
        checkOutput("stream_in_ready_fell", 32'(saw_nr), 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("stream_no_dup", 32'(out_valid_s), 32'd0);
        end

        // Fill both stages under backpressure, then reset mid-stream
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; a = 9'h040; b = 9'h020; sub = 1'b0;
        @(posedge clk); #1;
        a = 9'h0C0; b = 9'h0C0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("full_out_valid", 32'(out_valid_s), 32'd1);
        checkOutput("full_in_ready",  32'(in_ready_s),  32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("midrst_out_valid", 32'(out_valid_s), 32'd0);
        checkOutput("midrst_c",         32'(c_s),         32'd0);
        checkOutput("midrst_ovf",       32'(ovf_s),       32'd0);
        checkOutput("midrst_in_ready",  32'(in_ready_s),  32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("midrst_no_stale", 32'(out_valid_s), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fixed_point_addsub_pipe.md
Name: fixed_point_addsub_pipe

Overview:
Pipelined, parametrised fixed-point adder/subtractor with valid/ready streaming handshake. Operands of independent Q formats are aligned, added or subtracted at full precision, then rounded and saturated (or wrapped) into the output format, with a per-sample overflow flag. It replaces the asynchronous adder in the FIR datapath where timing closure and backpressure from downstream stages are needed.

Parameters:
A_FRAC_LEN, 8, fractional bits of a
A_WORD_LEN, 9, total bits of a (two's complement, A_WORD_LEN > A_FRAC_LEN)
B_FRAC_LEN, 8, fractional bits of b
B_WORD_LEN, 9, total bits of b
C_FRAC_LEN, 8, fractional bits of c
C_WORD_LEN, 9, total bits of c
ROUND_MODE, 0, 0 = truncate (toward -inf), 1 = round half up (toward +inf on ties)
SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands this cycle
a  in  A_WORD_LEN  signed operand a
b  in  B_WORD_LEN  signed operand b
sub  in  1  0: c = a + b, 1: c = a - b (sampled with a/b)
out_valid  out  1  c/ovf valid
out_ready  in  1  downstream accepts c this cycle
c  out  C_WORD_LEN  signed result
ovf  out  1  result exceeded C range (qualified by out_valid)

Behaviour:
- One clock; reset synchronous, active-low. Reset: out_valid=0, c=0, ovf=0, both stage-valid flags=0; in_ready=1 in the cycle after reset.
- Transfer on in_valid&&in_ready (input) and out_valid&&out_ready (output).
- Stage 1 (register S1): F = max(A_FRAC_LEN, B_FRAC_LEN, C_FRAC_LEN); I = max(A int bits, B int bits); sign-extend and left-shift both operands to I+F bits; compute full-precision sum/difference in I+F+1 bits (no loss possible).
- Stage 2 (register S2 = outputs): if F > C_FRAC_LEN, drop D = F - C_FRAC_LEN LSBs; ROUND_MODE=1 adds 2^(D-1) before dropping (rounding computed in one extra bit so it cannot wrap). If F == C_FRAC_LEN no rounding. Compare against C range [-2^(C_WORD_LEN-1), 2^(C_WORD_LEN-1)-1] in output LSBs; out of range -> ovf=1, c = clamp limit (SATURATE=1) or low C_WORD_LEN bits (SATURATE=0). In range -> ovf=0, c exact.
- Latency: 2 cycles accept-to-out_valid when not stalled; throughput 1/cycle with out_ready=1.
- Elastic pipeline: S2 loads when S2 empty or out_ready; S1 advances under the same condition; in_ready = !S1_valid || !S2_valid || out_ready (combinational from out_ready; bubbles collapse).
- Stall: out_valid&&!out_ready holds c, ovf, out_valid stable until accepted. Order preserved; no drop or duplicate.
- in_valid with in_ready=0: operands ignored; source must hold them.
- Simultaneous output accept and input accept with both stages full: all three slots shift in one cycle.
- rst_n low mid-stream: all in-flight samples discarded; no output after reset release until new inputs arrive.
- sub=1 with b = most-negative value: handled in extended width, no internal overflow.

Test Plan:
- Defaults (Q1.8), a=0x040, b=0x020, sub=0, out_ready=1 -> out_valid 2 cycles after accept, c=0x060, ovf=0.
- a=0x0C0, b=0x0C0, sub=0 -> SATURATE=1: c=0x0FF, ovf=1; SATURATE=0: c=0x180, ovf=1.
- a=0x100, b=0x001, sub=1 -> c=0x100, ovf=1 (SATURATE=1); a=0x000, b=0x100, sub=1 -> c=0x0FF, ovf=1.
- C_FRAC_LEN=4, C_WORD_LEN=5, b=0: a=0x018 -> ROUND_MODE=0 c=0x01, ROUND_MODE=1 c=0x02; a=0x1E8 -> ROUND_MODE=0 c=0x1E, ROUND_MODE=1 c=0x1F.
- Stream 6 back-to-back pairs, drop out_ready for 3 cycles after first out_valid -> in_ready falls once S1 and S2 full, c/ovf held stable, all 6 results exact and in order, no duplicates.
- Fill both stages, rst_n=0 for one cycle -> next cycle out_valid=0, c=0, ovf=0, in_ready=1; no stale result ever appears.
